// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the memory stage and DataMemory: word/address widths and FSM states.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package cpu_mem_pkg;

    // Default widths shared with DataMemory.
    localparam int MEM_DATA_W = 24;
    localparam int MEM_ADDR_W = 24;

    // Memory-stage controller states.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITE     = 2'd1,
        ST_READ_WAIT = 2'd2,
        ST_RESP      = 2'd3
    } state_t;

endpackage

// File: rtl/mem_access_unit.sv
// Memory-stage controller: one load/store at a time into DataMemory, result returned to writeback.
// Latency: fault 0, store 1, load READ_LAT cycles from the accept edge to RespValid.
// Backpressure: ReqReady low from accept until the cycle after the RespReady handoff.
module mem_access_unit
    import cpu_mem_pkg::*;
#(
    parameter int DATA_W    = MEM_DATA_W,
    parameter int ADDR_W    = MEM_ADDR_W,
    parameter int MEM_DEPTH = 256,
    parameter int READ_LAT  = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic              ReqWrite,
    input  logic [ADDR_W-1:0] ReqAddr,
    input  logic [DATA_W-1:0] ReqData,
    output logic              RespValid,
    input  logic              RespReady,
    output logic [DATA_W-1:0] RespData,
    output logic              RespWrite,
    output logic              RespErr,
    output logic [ADDR_W-1:0] Adresa,
    output logic [DATA_W-1:0] WriteData,
    output logic              MemWrite,
    output logic              MemRead,
    input  logic [DATA_W-1:0] ReadData
);

    // Wide enough for READ_LAT-1 over the whole legal 1..4 range.
    localparam int               CNT_W     = 3;
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(READ_LAT - 1);
    // One extra bit so MEM_DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W + 1)'(MEM_DEPTH);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              req_ready_nxt;
    logic              resp_valid_nxt;
    logic [DATA_W-1:0] resp_data_nxt;
    logic              resp_write_nxt;
    logic              resp_err_nxt;
    logic [ADDR_W-1:0] adresa_nxt;
    logic [DATA_W-1:0] write_data_nxt;
    logic              mem_write_nxt;
    logic              mem_read_nxt;
    logic              accept;
    logic              addr_fault;

    assign accept     = (state == ST_IDLE) && ReqReady && ReqValid;
    assign addr_fault = ({1'b0, ReqAddr} >= DEPTH_EXT);

    // State, counter and every output are registered; reset clears all, ReqReady included.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            ReqReady  <= 1'b0;
            RespValid <= 1'b0;
            RespData  <= '0;
            RespWrite <= 1'b0;
            RespErr   <= 1'b0;
            Adresa    <= '0;
            WriteData <= '0;
            MemWrite  <= 1'b0;
            MemRead   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            ReqReady  <= req_ready_nxt;
            RespValid <= resp_valid_nxt;
            RespData  <= resp_data_nxt;
            RespWrite <= resp_write_nxt;
            RespErr   <= resp_err_nxt;
            Adresa    <= adresa_nxt;
            WriteData <= write_data_nxt;
            MemWrite  <= mem_write_nxt;
            MemRead   <= mem_read_nxt;
        end
    end

    // Next-state and next-output logic; everything holds unless a transition changes it.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        req_ready_nxt  = ReqReady;
        resp_valid_nxt = RespValid;
        resp_data_nxt  = RespData;
        resp_write_nxt = RespWrite;
        resp_err_nxt   = RespErr;
        adresa_nxt     = Adresa;
        write_data_nxt = WriteData;
        mem_write_nxt  = MemWrite;
        mem_read_nxt   = MemRead;

        case (state)
            ST_IDLE: begin
                // ReqReady rises one edge after reset release, so an accept never
                // coincides with that first edge.
                req_ready_nxt = 1'b1;
                mem_write_nxt = 1'b0;
                mem_read_nxt  = 1'b0;
                if (accept) begin
                    req_ready_nxt  = 1'b0;
                    adresa_nxt     = ReqAddr;
                    write_data_nxt = ReqData;
                    if (addr_fault) begin
                        // Out-of-range: answer straight away, memory is never strobed.
                        state_nxt      = ST_RESP;
                        resp_valid_nxt = 1'b1;
                        resp_err_nxt   = 1'b1;
                        resp_data_nxt  = '0;
                        resp_write_nxt = ReqWrite;
                    end else if (ReqWrite) begin
                        state_nxt     = ST_WRITE;
                        mem_write_nxt = 1'b1;
                    end else begin
                        state_nxt    = ST_READ_WAIT;
                        mem_read_nxt = 1'b1;
                        cnt_nxt      = CNT_LOAD;
                    end
                end
            end

            ST_WRITE: begin
                // DataMemory captures on this edge; the strobe lasts exactly one cycle.
                state_nxt      = ST_RESP;
                mem_write_nxt  = 1'b0;
                resp_valid_nxt = 1'b1;
                resp_write_nxt = 1'b1;
                resp_err_nxt   = 1'b0;
                resp_data_nxt  = '0;
            end

            ST_READ_WAIT: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    state_nxt      = ST_RESP;
                    mem_read_nxt   = 1'b0;
                    resp_valid_nxt = 1'b1;
                    resp_write_nxt = 1'b0;
                    resp_err_nxt   = 1'b0;
                    resp_data_nxt  = ReadData;
                end
            end

            ST_RESP: begin
                // Response held until writeback takes it; ReqReady only returns afterwards.
                if (RespReady) begin
                    state_nxt      = ST_IDLE;
                    resp_valid_nxt = 1'b0;
                    resp_err_nxt   = 1'b0;
                    resp_data_nxt  = '0;
                    req_ready_nxt  = 1'b1;
                end
            end

            default: begin
                state_nxt     = ST_IDLE;
                mem_write_nxt = 1'b0;
                mem_read_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: two units (READ_LAT 1 and 3), each with its own DataMemory model.
// Latency: checked per transaction against a transaction-level reference model.
// Backpressure: RespReady held low for programmed cycles; stability and ReqReady checked.
module tb_mem_access_unit;

    localparam int RL0 = 1;
    localparam int RL1 = 3;
    localparam logic [23:0] JUNK = 24'h5A5A5A;

    logic             clk;
    logic             mem_clear;
    logic [1:0]       rst_n;
    logic [1:0]       req_valid, req_ready, req_write;
    logic [1:0][23:0] req_addr, req_data;
    logic [1:0]       resp_valid, resp_ready, resp_write, resp_err;
    logic [1:0][23:0] resp_data, adresa, write_data, read_data;
    logic [1:0]       mem_write, mem_read;
    logic [1:0][3:0]  rd_run;

    logic [23:0] dmem    [2][256];
    logic [23:0] ref_mem [2][256];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        wr;
        logic [23:0] addr;
        logic [23:0] data;
        int          hold;
        logic        exp_err;
        logic [23:0] exp_data;
    } vec_t;

    vec_t tbl [10];

    mem_access_unit #(.DATA_W(24), .ADDR_W(24), .MEM_DEPTH(256), .READ_LAT(RL0)) u_dut_rl1 (
        .Clock(clk), .Reset(rst_n[0]),
        .ReqValid(req_valid[0]), .ReqReady(req_ready[0]), .ReqWrite(req_write[0]),
        .ReqAddr(req_addr[0]), .ReqData(req_data[0]),
        .RespValid(resp_valid[0]), .RespReady(resp_ready[0]), .RespData(resp_data[0]),
        .RespWrite(resp_write[0]), .RespErr(resp_err[0]),
        .Adresa(adresa[0]), .WriteData(write_data[0]),
        .MemWrite(mem_write[0]), .MemRead(mem_read[0]), .ReadData(read_data[0])
    );

    mem_access_unit #(.DATA_W(24), .ADDR_W(24), .MEM_DEPTH(256), .READ_LAT(RL1)) u_dut_rl3 (
        .Clock(clk), .Reset(rst_n[1]),
        .ReqValid(req_valid[1]), .ReqReady(req_ready[1]), .ReqWrite(req_write[1]),
        .ReqAddr(req_addr[1]), .ReqData(req_data[1]),
        .RespValid(resp_valid[1]), .RespReady(resp_ready[1]), .RespData(resp_data[1]),
        .RespWrite(resp_write[1]), .RespErr(resp_err[1]),
        .Adresa(adresa[1]), .WriteData(write_data[1]),
        .MemWrite(mem_write[1]), .MemRead(mem_read[1]), .ReadData(read_data[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int u);
        return (u == 0) ? RL0 : RL1;
    endfunction

    // DataMemory stand-in: word write on MemWrite; ReadData is only meaningful once
    // MemRead has been held for the configured latency, junk otherwise.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (mem_clear) begin
                for (int i = 0; i < 256; i++) dmem[g][i] <= '0;
            end else if (mem_write[g]) begin
                dmem[g][adresa[g][7:0]] <= write_data[g];
            end
            if (!mem_read[g])            rd_run[g] <= '0;
            else if (rd_run[g] != 4'hF)  rd_run[g] <= rd_run[g] + 4'd1;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_rdata
        assign read_data[g] = (mem_read[g] && (int'(rd_run[g]) >= lat_of(g) - 1))
                              ? dmem[g][adresa[g][7:0]] : JUNK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One full transaction on unit u, from waiting for ReqReady to the response handoff.
    task automatic run_txn(input int u, input logic wr, input logic [23:0] addr,
                           input logic [23:0] dat, input int hold,
                           input logic exp_err, input logic [23:0] exp_data);
        int          exp_lat, lat, n_rd, n_wr, cyc, bad;
        logic [23:0] held;
        exp_lat = exp_err ? 0 : (wr ? 1 : lat_of(u));
        cyc = 0;
        while (req_ready[u] !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("req_ready_before_accept", 32'(req_ready[u]), 32'd1);
        req_valid[u] = 1'b1;
        req_write[u] = wr;
        req_addr[u]  = addr;
        req_data[u]  = dat;
        @(negedge clk);
        // Scramble the request lines: they must no longer matter.
        req_valid[u] = 1'b0;
        req_write[u] = ~wr;
        req_addr[u]  = 24'($urandom);
        req_data[u]  = 24'($urandom);
        check("adresa_latched", 32'(adresa[u]), 32'(addr));
        check("write_data_latched", 32'(write_data[u]), 32'(dat));
        lat = 0; n_rd = 0; n_wr = 0; bad = 0;
        while (resp_valid[u] !== 1'b1 && lat < 12) begin
            if (mem_read[u])  n_rd++;
            if (mem_write[u]) n_wr++;
            if (mem_read[u] && mem_write[u]) bad++;
            if (req_ready[u] !== 1'b0) bad++;
            if (adresa[u] !== addr) bad++;
            @(negedge clk);
            lat++;
        end
        check("resp_latency", 32'(lat), 32'(exp_lat));
        check("mem_write_cycles", 32'(n_wr), (wr && !exp_err) ? 32'd1 : 32'd0);
        check("mem_read_cycles", 32'(n_rd), (!wr && !exp_err) ? 32'(lat_of(u)) : 32'd0);
        check("resp_write", 32'(resp_write[u]), 32'(wr));
        check("resp_err", 32'(resp_err[u]), 32'(exp_err));
        check("resp_data", 32'(resp_data[u]), 32'(exp_data));
        held = resp_data[u];
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (resp_valid[u] !== 1'b1 || resp_data[u] !== held || resp_err[u] !== exp_err ||
                resp_write[u] !== wr || req_ready[u] !== 1'b0 || mem_read[u] !== 1'b0 ||
                mem_write[u] !== 1'b0 || adresa[u] !== addr) bad++;
        end
        check("in_flight_violations", 32'(bad), 32'd0);
        resp_ready[u] = 1'b1;
        @(negedge clk);
        resp_ready[u] = 1'b0;
        check("resp_valid_after_handoff", 32'(resp_valid[u]), 32'd0);
        check("resp_err_data_after_handoff", 32'({resp_err[u], resp_data[u]}), 32'd0);
        check("req_ready_after_handoff", 32'(req_ready[u]), 32'd1);
        check("adresa_stable_after_resp", 32'(adresa[u]), 32'(addr));
    endtask

    // Reference model: spec rules at transaction level, keeps its own memory image.
    task automatic model_txn(input int u, input logic wr, input logic [23:0] addr,
                             input logic [23:0] dat, input int hold);
        logic        err;
        logic [23:0] exp_d;
        err   = (addr >= 24'd256);
        exp_d = (err || wr) ? 24'h0 : ref_mem[u][addr[7:0]];
        run_txn(u, wr, addr, dat, hold, err, exp_d);
        if (wr && !err) ref_mem[u][addr[7:0]] = dat;
    endtask

    initial begin
        int bad;
        tbl[0] = '{1'b1, 24'd2,      24'h123456, 0, 1'b0, 24'h000000};
        tbl[1] = '{1'b0, 24'd2,      24'h000000, 0, 1'b0, 24'h123456};
        tbl[2] = '{1'b1, 24'd300,    24'hABCDEF, 1, 1'b1, 24'h000000};
        tbl[3] = '{1'b0, 24'd44,     24'h000000, 0, 1'b0, 24'h000000};
        tbl[4] = '{1'b1, 24'd255,    24'h0A5A5A, 2, 1'b0, 24'h000000};
        tbl[5] = '{1'b0, 24'd255,    24'h000000, 0, 1'b0, 24'h0A5A5A};
        tbl[6] = '{1'b0, 24'd256,    24'h000000, 0, 1'b1, 24'h000000};
        tbl[7] = '{1'b0, 24'hFFFFFF, 24'h000000, 1, 1'b1, 24'h000000};
        tbl[8] = '{1'b1, 24'd0,      24'hFFFFFF, 0, 1'b0, 24'h000000};
        tbl[9] = '{1'b0, 24'd0,      24'h000000, 3, 1'b0, 24'hFFFFFF};
        for (int u = 0; u < 2; u++)
            for (int i = 0; i < 256; i++) ref_mem[u][i] = '0;

        // Reset held two cycles with a request offered.
        mem_clear  = 1'b1;
        rst_n      = 2'b00;
        req_valid  = 2'b11;
        req_write  = 2'b11;
        req_addr   = {24'd2, 24'd2};
        req_data   = {24'h111111, 24'h111111};
        resp_ready = 2'b00;
        repeat (2) begin
            @(negedge clk);
            for (int u = 0; u < 2; u++)
                check("reset_outputs_zero",
                      32'(|{req_ready[u], resp_valid[u], resp_write[u], resp_err[u], mem_write[u],
                            mem_read[u], resp_data[u], adresa[u], write_data[u]}), 32'd0);
        end
        rst_n     = 2'b11;
        req_valid = 2'b00;
        mem_clear = 1'b0;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check("req_ready_after_reset", 32'(req_ready[u]), 32'd1);
            check("no_strobe_after_reset", 32'({mem_read[u], mem_write[u]}), 32'd0);
        end

        // Directed table on the READ_LAT=1 unit.
        for (int i = 0; i < 10; i++) begin
            run_txn(0, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].hold,
                    tbl[i].exp_err, tbl[i].exp_data);
            if (tbl[i].wr && !tbl[i].exp_err) ref_mem[0][tbl[i].addr[7:0]] = tbl[i].data;
            if (i == 2) check("fault_store_mem_untouched", 32'(dmem[0][44]), 32'd0);
        end

        // READ_LAT=3 unit: store, then load with writeback stalled four cycles.
        model_txn(1, 1'b1, 24'd2, 24'h123456, 0);
        run_txn(1, 1'b0, 24'd2, 24'h000000, 4, 1'b0, 24'h123456);

        // Reset pulled low in the middle of READ_WAIT aborts the load.
        req_valid[1] = 1'b1;
        req_write[1] = 1'b0;
        req_addr[1]  = 24'd2;
        @(negedge clk);
        req_valid[1] = 1'b0;
        check("abort_mem_read_active", 32'(mem_read[1]), 32'd1);
        @(negedge clk);
        rst_n[1] = 1'b0;
        @(negedge clk);
        check("abort_mem_read_cleared", 32'(mem_read[1]), 32'd0);
        check("abort_no_resp", 32'(resp_valid[1]), 32'd0);
        rst_n[1] = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp_valid[1] || mem_read[1] || mem_write[1]) bad++;
        end
        check("abort_quiet_after_reset", 32'(bad), 32'd0);
        check("abort_req_ready_back", 32'(req_ready[1]), 32'd1);
        run_txn(1, 1'b0, 24'd2, 24'h000000, 0, 1'b0, 24'h123456);

        // Randomized traffic against the reference model on both units.
        for (int u = 0; u < 2; u++) begin
            for (int n = 0; n < 30; n++) begin
                int          sel;
                logic [23:0] a;
                sel = $urandom_range(0, 9);
                if (sel <= 5)      a = 24'($urandom_range(0, 7));
                else if (sel == 6) a = 24'd255;
                else if (sel == 7) a = 24'd256;
                else if (sel == 8) a = 24'($urandom);
                else               a = 24'($urandom_range(0, 255));
                model_txn(u, 1'($urandom_range(0, 1)), a, 24'($urandom), $urandom_range(0, 3));
            end
        end

        // Final memory image must match the model's.
        for (int u = 0; u < 2; u++) begin
            bad = 0;
            for (int i = 0; i < 256; i++)
                if (dmem[u][i] !== ref_mem[u][i]) bad++;
            check("final_memory_image", 32'(bad), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the bench can never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
